// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
//   arb_state_e    : arbiter lock state (idle / locked to one requester)
//   BYTE_W         : width of one UART byte
//   MAX_REQ        : largest supported requester count
//   onehot_to_idx  : binary index of the set bit in a one-hot vector (up to MAX_REQ bits)
package uart_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int BYTE_W  = 8;
  localparam int MAX_REQ = 8;

  // An all-zero input maps to index 0; callers only use this on a valid grant.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker, reusable by any SoC arbiter.
//   req        in  N_REQ          request vector
//   last_owner in  $clog2(N_REQ)  index of the previous winner
//   win_onehot out N_REQ          one-hot winner (all zero when no request)
//   win_idx    out $clog2(N_REQ)  binary index of the winner (0 when no request)
// The scan starts at last_owner+1 and wraps, so the previous winner has the
// lowest priority.
module rr_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_owner,
  output logic [N_REQ-1:0]         win_onehot,
  output logic [$clog2(N_REQ)-1:0] win_idx
);

  localparam int IDX_W = $clog2(N_REQ);

  int               cand;
  logic             found;
  logic [IDX_W-1:0] cand_idx;

  // Walk every requester once, starting just after the previous winner.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(last_owner) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found                = 1'b1;
        win_onehot[cand_idx] = 1'b1;
        win_idx              = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte-stream requesters.
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_req_valid/data/last  per-requester byte stream (requester k data on [8k+7:8k])
//   o_req_ready        per-requester accept strobe (combinational)
//   o_tx_valid/o_tx_data, i_tx_ready  one-entry output register toward the UART
//   o_grant            one-hot current lock owner, zero when idle
//   o_busy             lock held or output register full
//   o_timeout          one-cycle pulse when a lock is dropped for inactivity
// Ownership is per message: the winner keeps the lock until it delivers a
// byte flagged last, or stays silent for TIMEOUT cycles (TIMEOUT=0 disables).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*BYTE_W-1:0] i_req_data,
  input  logic [N_REQ-1:0]        i_req_last,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_tx_valid,
  output logic [BYTE_W-1:0]       o_tx_data,
  input  logic                    i_tx_ready,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_busy,
  output logic                    o_timeout
);

  localparam int IDX_W = $clog2(N_REQ);
  // With the timeout disabled the counter is kept as a harmless 1-bit stub.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  arb_state_e        state;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  owner_idx;
  logic [IDX_W-1:0]  last_owner;
  logic [CNT_W-1:0]  idle_cnt;
  logic              tx_valid;
  logic [BYTE_W-1:0] tx_data;
  logic              timeout_pulse;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  released_idx;
  logic              owner_valid;
  logic              owner_last;
  logic [BYTE_W-1:0] owner_data;
  logic              tx_free;
  logic              accept;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req        (i_req_valid),
    .last_owner (last_owner),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx)
  );

  assign owner_valid  = i_req_valid[owner_idx];
  assign owner_last   = i_req_last[owner_idx];
  assign owner_data   = BYTE_W'(i_req_data >> {owner_idx, 3'b000});
  assign released_idx = IDX_W'(onehot_to_idx(MAX_REQ'(grant)));

  // The output register can take a new byte when empty or draining this cycle.
  assign tx_free = !tx_valid || i_tx_ready;
  assign accept  = (state == ARB_LOCKED) && owner_valid && tx_free;

  // grant is zero outside LOCKED, so only the owner can ever see ready.
  assign o_req_ready = accept ? grant : '0;
  assign o_tx_valid  = tx_valid;
  assign o_tx_data   = tx_data;
  assign o_grant     = grant;
  assign o_timeout   = timeout_pulse;
  assign o_busy      = (state == ARB_LOCKED) || tx_valid;

  // Lock FSM, idle counter and output register. Release (by last or timeout)
  // and a simultaneous output drain proceed independently.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ARB_IDLE;
      grant         <= '0;
      owner_idx     <= '0;
      last_owner    <= IDX_W'(N_REQ - 1);
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
    end else begin
      timeout_pulse <= 1'b0;

      if (accept) begin
        tx_valid <= 1'b1;
        tx_data  <= owner_data;
      end else if (i_tx_ready) begin
        tx_valid <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          if (|i_req_valid) begin
            state     <= ARB_LOCKED;
            grant     <= pick_onehot;
            owner_idx <= pick_idx;
            idle_cnt  <= '0;
          end
        end
        ARB_LOCKED: begin
          // A byte arriving on the threshold cycle takes precedence over timeout.
          if (accept && owner_last) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_owner <= released_idx;
          end else if (owner_valid) begin
            idle_cnt <= '0;
          end else if (TIMEOUT_EN && (idle_cnt == CNT_LAST)) begin
            state         <= ARB_IDLE;
            grant         <= '0;
            last_owner    <= released_idx;
            timeout_pulse <= 1'b1;
          end else if (idle_cnt != CNT_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=2, TIMEOUT=4).
// A message-level reference model runs alongside the DUT and is compared on
// every falling edge; directed scenarios add hand-computed literal checks.
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int TO = 4;

  typedef struct packed {
    logic       gap;
    logic       last;
    logic [7:0] data;
  } ent_t;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   o_req_ready;
  logic           o_tx_valid;
  logic [7:0]     o_tx_data;
  logic           tx_ready;
  logic [N-1:0]   o_grant;
  logic           o_busy;
  logic           o_timeout;

  int checks = 0;
  int errors = 0;

  ent_t       src_q [N][$];
  logic [7:0] drain_log[$];
  logic [7:0] grant_log[$];
  int         to_count = 0;
  logic [N-1:0] prev_grant = '0;

  int         m_owner      = -1;
  int         m_last_owner = N - 1;
  int         m_idle       = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_shown      = 8'h00;
  logic       m_to         = 1'b0;

  uart_tx_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (TO)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (o_req_ready),
    .o_tx_valid  (o_tx_valid),
    .o_tx_data   (o_tx_data),
    .i_tx_ready  (tx_ready),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Requester drivers: present queue heads, advance on a handshake seen at the
  // previous falling edge; gap entries hold valid low for one cycle.
  initial begin
    logic [N-1:0] hs;
    logic [N-1:0] was_gap;
    ent_t         e;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    was_gap   = '0;
    forever begin
      @(negedge clk);
      hs = o_req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if ((hs[k] || was_gap[k]) && src_q[k].size() > 0) void'(src_q[k].pop_front());
        was_gap[k] = 1'b0;
        if (src_q[k].size() > 0) begin
          e = src_q[k][0];
          if (e.gap) begin
            req_valid[k] = 1'b0;
            req_last[k]  = 1'b0;
            was_gap[k]   = 1'b1;
          end else begin
            req_valid[k]       = 1'b1;
            req_last[k]        = e.last;
            req_data[k*8 +: 8] = e.data;
          end
        end else begin
          req_valid[k] = 1'b0;
          req_last[k]  = 1'b0;
        end
      end
    end
  end

  // Reference model: who owns the lock, which bytes are queued for the UART.
  task automatic model_step();
    logic acc;
    int   c;
    acc  = (m_owner >= 0) && bit_of(req_valid, m_owner) && (m_q.size() == 0 || tx_ready);
    m_to = 1'b0;
    if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back(8'(req_data >> (8 * m_owner)));
      m_shown = 8'(req_data >> (8 * m_owner));
    end
    if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        c = (m_last_owner + i) % N;
        if (m_owner < 0 && bit_of(req_valid, c)) m_owner = c;
      end
      m_idle = 0;
    end else if (acc && bit_of(req_last, m_owner)) begin
      m_last_owner = m_owner;
      m_owner      = -1;
    end else if (bit_of(req_valid, m_owner)) begin
      m_idle = 0;
    end else if (TO != 0 && m_idle == TO - 1) begin
      m_to         = 1'b1;
      m_last_owner = m_owner;
      m_owner      = -1;
    end else begin
      m_idle++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner      = -1;
        m_last_owner = N - 1;
        m_idle       = 0;
        m_q.delete();
        m_shown      = 8'h00;
        m_to         = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle comparison against the model, plus logs for literal checks.
  initial begin
    logic [N-1:0] one;
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_ready;
    one = 1;
    forever begin
      @(negedge clk);
      exp_grant = (m_owner >= 0) ? (one << m_owner) : '0;
      exp_ready = ((m_owner >= 0) && bit_of(req_valid, m_owner) && (m_q.size() == 0 || tx_ready))
                  ? exp_grant : '0;
      check_eq("model_grant", o_grant, exp_grant);
      check_eq("model_ready", o_req_ready, exp_ready);
      check_eq("model_tx_valid", o_tx_valid, m_q.size() > 0);
      check_eq("model_tx_data", o_tx_data, (m_q.size() > 0) ? m_q[0] : m_shown);
      check_eq("model_busy", o_busy, (m_owner >= 0) || (m_q.size() > 0));
      check_eq("model_timeout", o_timeout, m_to);
      if (o_tx_valid && tx_ready) drain_log.push_back(o_tx_data);
      if (o_grant != '0 && o_grant != prev_grant) grant_log.push_back(8'(o_grant));
      prev_grant = o_grant;
      if (o_timeout) to_count++;
    end
  end

  task automatic push(input int k, input logic [7:0] d, input logic l);
    ent_t e;
    e.gap = 1'b0; e.last = l; e.data = d;
    src_q[k].push_back(e);
  endtask

  task automatic push_gap(input int k);
    ent_t e;
    e.gap = 1'b1; e.last = 1'b0; e.data = 8'h00;
    src_q[k].push_back(e);
  endtask

  task automatic apply_stimulus_sync();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    drain_log.delete();
    grant_log.delete();
    to_count = 0;
  endtask

  task automatic wait_drained(input int n, input int budget, input string name);
    int c = 0;
    while (drain_log.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (drain_log.size() < n) fail_bound(name);
  endtask

  task automatic wait_tx_valid(input int budget, input string name);
    int c = 0;
    @(negedge clk);
    while (!o_tx_valid && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (!o_tx_valid) fail_bound(name);
  endtask

  // Compare a log against n bytes packed most-significant first.
  task automatic check_output(input string name, input bit use_grant, input logic [63:0] exp, input int n);
    int         sz;
    logic [7:0] got;
    sz = use_grant ? grant_log.size() : drain_log.size();
    check_eq({name, "_len"}, sz, n);
    for (int i = 0; i < n; i++) begin
      if (i < sz) got = use_grant ? grant_log[i] : drain_log[i];
      else        got = 'x;
      check_eq($sformatf("%s[%0d]", name, i), got, exp[8*(n-1-i) +: 8]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int idle_seen;
    int c;
    tx_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check_eq("reset_grant", o_grant, 2'b00);
    check_eq("reset_tx_valid", o_tx_valid, 1'b0);
    check_eq("reset_tx_data", o_tx_data, 8'h00);
    check_eq("reset_timeout", o_timeout, 1'b0);
    check_eq("reset_busy", o_busy, 1'b0);
    rst_n = 1'b1;

    $display("[TB] single message");
    apply_stimulus_sync();
    clear_logs();
    push(0, 8'h48, 1'b0);
    push(0, 8'h69, 1'b1);
    c = 0;
    @(negedge clk);
    while (!req_valid[0] && c < 10) begin @(negedge clk); c++; end
    if (!req_valid[0]) fail_bound("t1_valid");
    check_eq("t1_no_ready_in_idle", o_req_ready, 2'b00);
    @(negedge clk);
    check_eq("t1_grant", o_grant, 2'b01);
    @(negedge clk);
    check_eq("t1_tx_valid", o_tx_valid, 1'b1);
    check_eq("t1_byte0", o_tx_data, 8'h48);
    @(negedge clk);
    check_eq("t1_byte1", o_tx_data, 8'h69);
    check_eq("t1_idle_grant", o_grant, 2'b00);
    check_eq("t1_busy_draining", o_busy, 1'b1);
    wait_drained(2, 20, "t1_drain");
    @(negedge clk);
    check_eq("t1_busy_done", o_busy, 1'b0);
    check_eq("t1_data_kept", o_tx_data, 8'h69);
    check_output("t1_bytes", 1'b0, 64'h4869, 2);

    $display("[TB] fairness");
    apply_stimulus_sync();
    clear_logs();
    push(0, 8'h20, 1'b0); push(0, 8'h21, 1'b1); push(0, 8'h22, 1'b0); push(0, 8'h23, 1'b1);
    push(1, 8'h30, 1'b0); push(1, 8'h31, 1'b1); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b1);
    wait_drained(8, 100, "t2_drain");
    check_output("t2_bytes", 1'b0, 64'h3031_2021_3233_2223, 8);
    check_output("t2_grants", 1'b1, 64'h0201_0201, 4);

    $display("[TB] backpressure");
    apply_stimulus_sync();
    clear_logs();
    tx_ready = 1'b0;
    push(0, 8'hA5, 1'b1);
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
    wait_tx_valid(10, "t3_load");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t3_hold_data", o_tx_data, 8'hA5);
      check_eq("t3_hold_ready", o_req_ready, 2'b00);
    end
    apply_stimulus_sync();
    tx_ready = 1'b1;
    wait_drained(4, 40, "t3_drain");
    check_output("t3_bytes", 1'b0, 64'hA501_0203, 4);
    check_output("t3_grants", 1'b1, 64'h0101, 2);
    check_eq("t3_no_timeout", to_count, 0);

    $display("[TB] timeout");
    apply_stimulus_sync();
    clear_logs();
    push(1, 8'h10, 1'b0);
    push(0, 8'h40, 1'b1);
    idle_seen = 0;
    c = 0;
    @(negedge clk);
    while (!o_timeout && c < 30) begin
      if (o_grant == 2'b10 && !req_valid[1]) idle_seen++;
      @(negedge clk);
      c++;
    end
    if (!o_timeout) fail_bound("t4_timeout");
    check_eq("t4_idle_cycles", idle_seen, 4);
    check_eq("t4_released", o_grant, 2'b00);
    wait_drained(2, 20, "t4_drain");
    check_output("t4_bytes", 1'b0, 64'h1040, 2);
    check_output("t4_grants", 1'b1, 64'h0201, 2);
    check_eq("t4_timeout_count", to_count, 1);

    $display("[TB] threshold race");
    apply_stimulus_sync();
    clear_logs();
    push(1, 8'h10, 1'b0);
    push_gap(1); push_gap(1); push_gap(1);
    push(1, 8'h11, 1'b1);
    wait_drained(2, 30, "t5_drain");
    check_output("t5_bytes", 1'b0, 64'h1011, 2);
    check_output("t5_grants", 1'b1, 64'h02, 1);
    check_eq("t5_no_timeout", to_count, 0);

    $display("[TB] reset mid-message");
    apply_stimulus_sync();
    clear_logs();
    tx_ready = 1'b0;
    push(0, 8'h77, 1'b0);
    push(0, 8'h78, 1'b1);
    wait_tx_valid(10, "t6_load");
    #2;
    rst_n = 1'b0;
    src_q[0].delete();
    src_q[1].delete();
    #1;
    check_eq("t6_tx_valid", o_tx_valid, 1'b0);
    check_eq("t6_grant", o_grant, 2'b00);
    check_eq("t6_timeout", o_timeout, 1'b0);
    check_eq("t6_busy", o_busy, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    apply_stimulus_sync();
    clear_logs();
    push(0, 8'h50, 1'b1);
    push(1, 8'h60, 1'b1);
    wait_drained(2, 30, "t6_drain");
    check_output("t6_bytes", 1'b0, 64'h5060, 2);
    check_output("t6_grants", 1'b1, 64'h0102, 2);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the SoC's single UART transmitter between N byte-stream requesters, e.g. requester 0 = CPU MMIO writes and requester 1 = a hardware debug/status streamer.
- Round-robin arbitration at message granularity: a granted requester keeps the transmitter until it sends a byte flagged last, or until its idle timeout expires.
- A one-entry output register decouples requesters from the UART byte interface.
- Sits between the requesters and the UART transmitter inside rv_soc.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- TIMEOUT, 1024, max consecutive idle cycles (owner not asserting valid) before the lock is forcibly released; 0 disables the timeout

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_req_valid  in  N_REQ  per-requester byte valid
- i_req_data  in  N_REQ*8  requester k byte on bits [8k+7:8k]
- i_req_last  in  N_REQ  byte is the final byte of its message
- o_req_ready  out  N_REQ  per-requester byte accepted this cycle (combinational)
- o_tx_valid  out  1  byte available to the UART
- o_tx_data  out  8  byte to transmit
- i_tx_ready  in  1  UART accepts o_tx_data this cycle
- o_grant  out  N_REQ  one-hot current owner; all zero when idle
- o_busy  out  1  lock held or output register full
- o_timeout  out  1  one-cycle pulse when a lock is released by timeout

Behaviour:
- Reset (async assert, sync deassert):
  - State is IDLE.
  - o_tx_valid=0, o_tx_data=0, o_grant=0, o_timeout=0.
  - last_owner=N_REQ-1, so requester 0 has first priority.
  - Idle counter=0.
- IDLE state:
  - If any i_req_valid is set, choose the first set bit scanning from last_owner+1 upward with wrap.
  - Next cycle: state LOCKED, o_grant=onehot(winner), idle counter=0.
  - Arbitration costs one cycle; no byte is accepted in IDLE.
- LOCKED state, owner g:
  - o_req_ready[g] = i_req_valid[g] && (!o_tx_valid || i_tx_ready).
  - o_req_ready for every other requester is 0.
- On acceptance:
  - The byte loads the output register at the next edge, giving 1-cycle latency to o_tx_valid.
  - Simultaneous drain and load is allowed, giving full throughput of one byte per cycle when i_tx_ready is held high.
- Lock release on last:
  - Accepting a byte with i_req_last[g]=1 returns the state to IDLE next cycle and sets last_owner=g.
  - The output register may still hold that byte; arbitration proceeds in parallel with the drain.
- Idle counter and timeout:
  - In LOCKED, the counter increments on each cycle with i_req_valid[g]=0 and clears on each cycle with i_req_valid[g]=1.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with valid still low, the next cycle is IDLE, last_owner=g, and o_timeout pulses for exactly that cycle.
  - A valid byte in the same cycle as the threshold wins: it is accepted and there is no timeout.
  - Counter width is $clog2(TIMEOUT+1) and it saturates; it never wraps.
- Output register:
  - o_tx_valid holds until i_tx_ready.
  - o_tx_data is stable while o_tx_valid=1 && !i_tx_ready.
  - o_tx_data keeps its last value after a drain; it is not cleared.
- Backpressure: with i_tx_ready=0 and the register full, o_req_ready=0 and the idle counter does not advance, because valid is high.
- Requester drops valid mid-message: the lock is kept (no other requester can interleave) until last or timeout.
- Reset asserted mid-message: the pending output byte is discarded, i.e. o_tx_valid=0 immediately.
- o_busy = (state==LOCKED) || o_tx_valid.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum {ARB_IDLE, ARB_LOCKED}
  - a byte-width constant of 8
  - the function onehot_to_idx
- One sub-module, rr_pick:
  - inputs: request vector, last_owner index
  - outputs: one-hot winner and winner index
  - purely combinational
  - reusable by other SoC arbiters

Test Plan:
- Single message: req0 sends 0x48,0x69(last) with i_tx_ready=1 → grant0 one cycle after valid; o_tx_data 0x48 then 0x69 on consecutive cycles; state IDLE after the 0x69 acceptance.
- Fairness: req0 and req1 both continuously send 2-byte messages → o_grant alternates 01,10,01,10; no byte interleaving within a message.
- Backpressure: i_tx_ready=0 for 5 cycles with 0xA5 in the register → o_tx_data stays 0xA5, o_req_ready=0, no data lost; 3-byte message 0x01,0x02,0x03 emerges in order once ready returns.
- Timeout (TIMEOUT=4): req1 sends 0x10 (not last) then drops valid while req0 waits → o_timeout pulses after 4 idle cycles; req0 granted on the next arbitration.
- Threshold race (TIMEOUT=4): req1 reasserts valid on idle cycle 4 with 0x11 → byte accepted, no o_timeout, grant retained.
- Reset mid-message: assert i_reset_n=0 while o_tx_valid=1 → o_tx_valid, o_grant, o_timeout all 0 asynchronously; after release, req0 wins first.
